// File: rtl/parser_pkg.sv
// Shared parser constants, tags and ingress head-builder types.
// Head/meta widths are reused by the parser pipeline and its ingress stage.
package parser_pkg;

    localparam int HEAD_WIDTH    = 512;
    localparam int META_WIDTH    = 64;
    localparam int TAG_START_BIT = 4;
    localparam int TAG_WIDTH     = TAG_START_BIT + 4;

    localparam logic [TAG_WIDTH-1:0] HEAD_TAG_VALID =
        {4'b1101, {TAG_START_BIT{1'b1}}};
    localparam logic [TAG_WIDTH-1:0] META_TAG_VALID =
        {4'b1111, {TAG_START_BIT{1'b0}}};

    localparam int META_LEN_LSB   = 0;
    localparam int META_PKTID_LSB = 16;
    localparam int META_LONG_BIT  = 32;

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        EMIT
    } hb_state_e;

endpackage

// File: rtl/hb_keep_count.sv
// Byte-enable popcount for one input beat.
// Purely combinational; feeds the packet length accumulator.
module hb_keep_count #(
    parameter int KW = 16,
    parameter int CW = $clog2(KW) + 1
) (
    input  logic [KW-1:0] keep,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KW; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/parser_head_builder.sv
// Ingress stage: packs the first HEAD_WIDTH bits of a packet into a
// tagged head vector plus a tagged meta vector, emitted as a 1-cycle pulse.
module parser_head_builder #(
    parameter int BEAT_WIDTH = 128,
    parameter int HEAD_WIDTH = parser_pkg::HEAD_WIDTH,
    parameter int META_WIDTH = parser_pkg::META_WIDTH,
    parameter int TAG_WIDTH  = parser_pkg::TAG_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_data_valid,
    input  logic [BEAT_WIDTH-1:0]            i_data,
    input  logic [BEAT_WIDTH/8-1:0]          i_data_keep,
    input  logic                             i_data_last,
    output logic                             o_data_ready,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta
);
    import parser_pkg::*;

    localparam int HB = HEAD_WIDTH / BEAT_WIDTH;
    localparam int KB = BEAT_WIDTH / 8;
    localparam int CW = $clog2(HB + 1);
    localparam int PW = $clog2(KB) + 1;

    hb_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [15:0]           len_q;
    logic [15:0]           pkt_id;
    logic                  long_q;
    logic [HEAD_WIDTH-1:0] head_q;
    logic                  ready_d;
    logic                  accept;
    logic [PW-1:0]         keep_n;
    logic [BEAT_WIDTH-1:0] beat_m;
    logic [16:0]           len_sum;
    logic [15:0]           len_d;
    logic [META_WIDTH-1:0] meta_w;

    assign accept = i_data_valid && o_data_ready;

    hb_keep_count #(
        .KW(KB),
        .CW(PW)
    ) u_keep_count (
        .keep (i_data_keep),
        .count(keep_n)
    );

    always_comb begin
        beat_m = '0;
        for (int b = 0; b < KB; b++) begin
            if (i_data_keep[b]) beat_m[b*8 +: 8] = i_data[b*8 +: 8];
        end
    end

    assign len_sum = {1'b0, len_q} + 17'(keep_n);
    assign len_d   = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= COLLECT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (i_data_last)                  state_d = EMIT;
                    else if (cnt_q == CW'(HB - 1))    state_d = DRAIN;
                end
            end
            DRAIN:   if (accept && i_data_last) state_d = EMIT;
            EMIT:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Registered so ready is low throughout reset and during EMIT only.
    always_comb ready_d = (state_d != EMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_data_ready <= 1'b0;
        else          o_data_ready <= ready_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            long_q <= 1'b0;
            head_q <= '0;
            pkt_id <= '0;
        end else if (state_q == EMIT) begin
            cnt_q  <= '0;
            len_q  <= '0;
            long_q <= 1'b0;
            head_q <= '0;
            pkt_id <= pkt_id + 16'd1;
        end else if (accept) begin
            for (int k = 0; k < HB; k++) begin
                if (cnt_q == CW'(k))
                    head_q[HEAD_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH] <= beat_m;
            end
            if (cnt_q < CW'(HB)) cnt_q <= cnt_q + CW'(1);
            len_q <= len_d;
            if (state_q == DRAIN) long_q <= 1'b1;
        end
    end

    always_comb begin
        meta_w = '0;
        meta_w[META_LEN_LSB   +: 16] = len_q;
        meta_w[META_PKTID_LSB +: 16] = pkt_id;
        meta_w[META_LONG_BIT]        = long_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_head <= '0;
            o_meta <= '0;
        end else if (state_q == EMIT) begin
            o_head <= {TAG_WIDTH'(HEAD_TAG_VALID), head_q};
            o_meta <= {TAG_WIDTH'(META_TAG_VALID), meta_w};
        end else begin
            o_head <= '0;
            o_meta <= '0;
        end
    end

endmodule

// File: tb/tb_parser_head_builder.sv
// Directed-vector bench for parser_head_builder.
// Expected head/meta words are hand-built from the packet tables below.
module tb_parser_head_builder;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_data_valid;
    logic [127:0] i_data;
    logic [15:0]  i_data_keep;
    logic         i_data_last;
    logic         o_data_ready;
    logic [519:0] o_head;
    logic [71:0]  o_meta;

    int n_vec = 0;
    int n_err = 0;
    int stalls;

    logic [127:0] bd [8];
    logic [15:0]  bk [8];

    parser_head_builder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data_valid(i_data_valid),
        .i_data      (i_data),
        .i_data_keep (i_data_keep),
        .i_data_last (i_data_last),
        .o_data_ready(o_data_ready),
        .o_head      (o_head),
        .o_meta      (o_meta)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [575:0] obs,
                         input logic [575:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk_meta(input logic [15:0] len,
                                            input logic [15:0] id,
                                            input logic lng);
        return {8'hF0, 31'b0, lng, id, len};
    endfunction

    task automatic wait_acc();
        int t = 0;
        while (!o_data_ready && t < 20) begin
            @(negedge i_clk);
            t++;
            stalls++;
        end
        check("acc_wait", 576'(o_data_ready), 576'(1'b1));
        @(negedge i_clk);
    endtask

    task automatic send_pkt(input int n);
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            i_data_valid = 1'b1;
            i_data       = bd[k];
            i_data_keep  = bk[k];
            i_data_last  = (k == n - 1);
            wait_acc();
        end
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
    endtask

    // Called right after last-beat acceptance; checks EMIT gap and pulse.
    task automatic check_out(input string tag, input logic [519:0] eh,
                             input logic [71:0] em);
        check({tag, "_rdy_emit"}, 576'(o_data_ready), 576'(1'b0));
        check({tag, "_early"}, 576'(o_head), 576'(0));
        @(negedge i_clk);
        check({tag, "_head"}, 576'(o_head), 576'(eh));
        check({tag, "_meta"}, 576'(o_meta), 576'(em));
        check({tag, "_rdy_back"}, 576'(o_data_ready), 576'(1'b1));
        @(negedge i_clk);
        check({tag, "_head_clr"}, 576'(o_head), 576'(0));
        check({tag, "_meta_clr"}, 576'(o_meta), 576'(0));
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        logic [127:0] x;
        logic [519:0] eh;
        i_rst_n      = 1'b0;
        i_data_valid = 1'b0;
        i_data       = '0;
        i_data_keep  = '0;
        i_data_last  = 1'b0;
        @(negedge i_clk);
        check("rst_head", 576'(o_head), 576'(0));
        check("rst_meta", 576'(o_meta), 576'(0));
        check("rst_rdy", 576'(o_data_ready), 576'(1'b0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 1: 64B TCP frame
        bd[0] = 128'h000a3500010200e04c36010208004500;
        bd[1] = 128'h0028000040004006b7c2c0a80001c0a8;
        bd[2] = 128'h0002d43101bb00000000000000005002;
        bd[3] = 128'h20000000000000000000000000000000;
        for (int k = 0; k < 4; k++) bk[k] = 16'hFFFF;
        send_pkt(4);
        check_out("tcp", {8'hDF, bd[0], bd[1], bd[2], bd[3]},
                  mk_meta(16'd64, 16'd0, 1'b0));

        // 2: ARP, 28 bytes, trailing 4 bytes masked off
        bd[0] = 128'hffffffffffff00e04c36010208060001;
        bd[1] = 128'h08000604000100e04c360102deadbeef;
        bk[0] = 16'hFFFF;
        bk[1] = 16'hFFF0;
        send_pkt(2);
        check_out("arp", {8'hDF, bd[0], 128'h08000604000100e04c36010200000000,
                          256'b0},
                  mk_meta(16'd28, 16'd1, 1'b0));

        // 3: 6-beat long packet, last beat 8 bytes
        for (int k = 0; k < 6; k++) begin
            bd[k] = {16{8'(8'h10 + k)}};
            bk[k] = 16'hFFFF;
        end
        bk[5] = 16'hFF00;
        send_pkt(6);
        check("long_stalls", 576'(stalls), 576'(0));
        check_out("long", {8'hDF, bd[0], bd[1], bd[2], bd[3]},
                  mk_meta(16'd88, 16'd2, 1'b1));

        // 4: three back-to-back single-beat packets
        do_reset();
        x = 128'h0123456789abcdef0011223344556677;
        eh = {8'hDF, x, 384'b0};
        i_data_valid = 1'b1;
        i_data       = x;
        i_data_keep  = 16'hFFFF;
        i_data_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b_rdy%0d", i), 576'(o_data_ready),
                  576'(i % 2 == 0));
            if (i == 2 || i == 4) begin
                check($sformatf("b2b_meta%0d", i / 2 - 1), 576'(o_meta),
                      576'(mk_meta(16'd16, 16'(i / 2 - 1), 1'b0)));
                check($sformatf("b2b_head%0d", i / 2 - 1), 576'(o_head),
                      576'(eh));
            end
            @(negedge i_clk);
        end
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        check("b2b_meta2", 576'(o_meta), 576'(mk_meta(16'd16, 16'd2, 1'b0)));

        // 5: reset mid-packet, then a fresh single beat
        for (int k = 0; k < 4; k++) begin
            bd[k] = {4{32'(32'hA0A0A0A0 + k)}};
            bk[k] = 16'hFFFF;
        end
        for (int k = 0; k < 2; k++) begin
            i_data_valid = 1'b1;
            i_data       = bd[k];
            i_data_keep  = bk[k];
            i_data_last  = 1'b0;
            wait_acc();
        end
        i_data_valid = 1'b0;
        do_reset();
        repeat (3) begin
            check("abort_quiet", 576'(o_head), 576'(0));
            @(negedge i_clk);
        end
        bd[0] = 128'hcafef00d000000000000000012345678;
        bk[0] = 16'hFFFF;
        send_pkt(1);
        check_out("post_rst", {8'hDF, bd[0], 384'b0},
                  mk_meta(16'd16, 16'd0, 1'b0));

        // 6: pkt_id wrap
        force dut.pkt_id = 16'hFFFF;
        @(negedge i_clk);
        release dut.pkt_id;
        send_pkt(1);
        check_out("wrap_ff", {8'hDF, bd[0], 384'b0},
                  mk_meta(16'd16, 16'hFFFF, 1'b0));
        send_pkt(1);
        check_out("wrap_00", {8'hDF, bd[0], 384'b0},
                  mk_meta(16'd16, 16'h0000, 1'b0));

        // single beat with no valid bytes still emits, length 0
        bk[0] = 16'h0000;
        send_pkt(1);
        check_out("zero_len", 520'({8'hDF, 512'b0}),
                  mk_meta(16'd0, 16'd1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
